// File: rtl/cla_sub_pipe.sv
// Pipelined carry-lookahead subtractor: diff = minuend - subtrahend - bin.
// One SLICE-bit lookahead slice is resolved per stage, and the borrow between
// slices is registered. Operand slices that are not yet used travel down the
// pipe in skew registers. Finished result slices are carried forward, so every
// field on the outputs belongs to the same beat.
// The whole pipe advances together and freezes whenever the output is stalled.
// WIDTH must be a multiple of SLICE and give at least two stages.
module cla_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SLICE;

  // One slice of A + ~B + cin. Every internal carry is built in lookahead form
  // from the generate/propagate terms and cin, not by rippling bit to bit.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] nb,
                                               input logic             cin);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             t;
    g = a & nb;
    p = a ^ nb;
    c = '0;
    c[0] = cin;
    for (int i = 1; i <= SLICE; i++) begin
      t = cin;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // Pipeline state. Index k is stage k. The skew registers exist only for
  // stages that still have a later stage to feed.
  logic [STAGES-1:0]             v_q;
  logic [STAGES-1:0]             br_q;
  logic [STAGES-1:0][WIDTH-1:0]  r_q;
  logic [STAGES-2:0][WIDTH-1:0]  a_q;
  logic [STAGES-2:0][WIDTH-1:0]  b_q;
  logic                          ovf_q;
  logic                          zero_q;

  // Inputs to each stage and that stage's next-state values.
  logic [STAGES-1:0][WIDTH-1:0]  sa;
  logic [STAGES-1:0][WIDTH-1:0]  sb;
  logic [STAGES-1:0][WIDTH-1:0]  pr;
  logic [STAGES-1:0]             ci;
  logic [STAGES-1:0]             vi;
  logic [STAGES-1:0][SLICE:0]    sl;
  logic [STAGES-1:0][WIDTH-1:0]  r_n;
  logic [STAGES-1:0]             br_n;
  logic                          ovf_n;
  logic                          zero_n;

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Stage 0 takes its operands straight from the ports. The borrow in
      // becomes the inverted carry into slice 0.
      assign sa[k] = minuend;
      assign sb[k] = subtrahend;
      assign pr[k] = '0;
      assign ci[k] = ~bin;
      assign vi[k] = in_valid;
    end else begin : g_next
      assign sa[k] = a_q[k-1];
      assign sb[k] = b_q[k-1];
      assign pr[k] = r_q[k-1];
      assign ci[k] = ~br_q[k-1];
      assign vi[k] = v_q[k-1];
    end

    assign sl[k] = cla_slice(sa[k][k*SLICE +: SLICE], ~sb[k][k*SLICE +: SLICE], ci[k]);

    // Slices above k are still zero in the forwarded result, so OR-ing the new
    // slice into place is enough.
    assign r_n[k]  = pr[k] | ({{(WIDTH-SLICE){1'b0}}, sl[k][SLICE-1:0]} << (k*SLICE));
    assign br_n[k] = ~sl[k][SLICE];
  end

  // The last stage produces the flags from operand sign bits of the same beat.
  assign ovf_n  = (sa[STAGES-1][WIDTH-1] ^ sb[STAGES-1][WIDTH-1]) &
                  (sa[STAGES-1][WIDTH-1] ^ r_n[STAGES-1][WIDTH-1]);
  assign zero_n = (r_n[STAGES-1] == '0);

  // Move every stage forward in lock step unless the output is stalled.
  // Reset drops in-flight beats and clears all data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      br_q   <= '0;
      r_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      v_q    <= vi;
      br_q   <= br_n;
      r_q    <= r_n;
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= sa[k];
        b_q[k] <= sb[k];
      end
      ovf_q  <= ovf_n;
      zero_q <= zero_n;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign diff      = r_q[STAGES-1];
  assign bout      = br_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe. A queue-based arithmetic model predicts every result
// beat. The bench runs directed boundary beats, a back-to-back stream, random
// backpressure, and an asynchronous reset taken mid-stream.
module tb_cla_sub_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  res_t expq[$];
  int   nerr = 0;
  int   nchk = 0;
  int   n_out = 0;
  logic prev_stall = 1'b0;
  res_t held;
  logic got_out;
  res_t last_out;

  cla_sub_pipe #(.WIDTH(32), .SLICE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .bout       (bout),
    .ovf        (ovf),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the result is plain integer subtraction. The borrow is set when
  // the true result is negative. Overflow is set when the signed result leaves
  // the 32-bit range.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
    res_t   r;
    longint s;
    longint ss;
    s    = longint'(a) - longint'(b) - longint'(c);
    ss   = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
    r.d  = s[31:0];
    r.bo = (s < 0);
    r.ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    r.z  = (r.d == 32'h0);
    return r;
  endfunction

  // One clock: sample just after the falling edge, then return just after the
  // rising edge so the caller can set up the next beat.
  task automatic cycle();
    logic exp_rdy;
    res_t cur;
    res_t obs;
    @(negedge clk);
    #1;
    obs     = {diff, bout, ovf, zero};
    exp_rdy = ~(out_valid & ~out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'(obs), 64'(held));
    end
    got_out = 1'b0;
    if (out_valid && out_ready) begin
      got_out  = 1'b1;
      last_out = obs;
      n_out++;
      if (expq.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        cur = expq.pop_front();
        chk("result", 64'(obs), 64'(cur));
      end
    end
    if (in_valid && in_ready) expq.push_back(model(minuend, subtrahend, bin));
    prev_stall = out_valid & ~out_ready;
    held       = obs;
    @(posedge clk);
    #1;
  endtask

  // A single beat into an idle pipe. The bench checks the latency and the
  // result against fixed expected values.
  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic c, input res_t exp);
    int n;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    minuend    = a;
    subtrahend = b;
    bin        = c;
    cycle();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n++;
      if (got_out) break;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    chk(tag, 64'(last_out), 64'(exp));
  endtask

  initial begin
    int   bound;
    int   base;
    res_t obs;

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    minuend    = '0;
    subtrahend = '0;
    bin        = 1'b0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({diff, bout, ovf, zero}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    dir("t1_basic",     32'h0000_0010, 32'h0000_0001, 1'b0, '{32'h0000_000F, 1'b0, 1'b0, 1'b0});
    dir("t2_zero_bin",  32'h0000_0000, 32'h0000_0000, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
    dir("t2_equal",     32'h1234_5678, 32'h1234_5678, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1});
    dir("t2_slice_brw", 32'h0000_0100, 32'h0000_0001, 1'b0, '{32'h0000_00FF, 1'b0, 1'b0, 1'b0});
    dir("t3_neg_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    dir("t3_pos_ovf",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h8000_0000, 1'b1, 1'b1, 1'b0});

    // Twenty back-to-back beats with no backpressure.
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid   = 1'b1;
      minuend    = $urandom;
      subtrahend = $urandom;
      bin        = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("stream_count", 64'(n_out - base), 64'd20);
    chk("stream_drained", 64'(expq.size()), 64'd0);

    // Random valid and random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 9) < 6);
      minuend    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      subtrahend = ($urandom_range(0, 7) == 0) ? minuend : $urandom;
      bin        = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bound = 0;
    while (expq.size() != 0 && bound < 20) begin
      cycle();
      bound++;
    end
    chk("random_drained", 64'(expq.size()), 64'd0);

    // Asynchronous reset with beats still in the pipe.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      minuend    = $urandom;
      subtrahend = $urandom;
      bin        = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0;
    #2;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    obs = {diff, bout, ovf, zero};
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_outputs", 64'(obs), 64'd0);
    chk("async_reset_in_ready", 64'(in_ready), 64'd1);
    expq.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    dir("t6_after_reset", 32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0});
    chk("final_drained", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
